// File: rtl/mdu_alu.sv
// mdu_alu: RV32I/RV64I integer ALU plus M-extension behind a valid/ready handshake.
// Ports: clk, rst (async, active high); request in_valid/in_ready/in_op/in_a/in_b;
//        kill aborts in-flight work; response out_valid/out_ready/out_result/out_illegal.
module mdu_alu #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_EQ     = 5'd10;
    localparam logic [4:0] OP_NE     = 5'd11;
    localparam logic [4:0] OP_GE     = 5'd12;
    localparam logic [4:0] OP_GEU    = 5'd13;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ZPAD    = '0;

    typedef enum logic {S_IDLE, S_DIV} state_e;

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    out_result_q, out_result_d;
    logic               out_illegal_q, out_illegal_d;
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    quo_q, quo_d;
    logic [XLEN-1:0]    dvs_q, dvs_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               want_rem_q, want_rem_d;

    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;
    logic               alu_ill;
    logic               is_div;
    logic [2*XLEN-1:0]  mul_a, mul_b, mul_p;
    logic               div_sgn, div_rem, b_zero, ovf, fast;
    logic [XLEN-1:0]    abs_a, abs_b, fast_res;
    logic [XLEN:0]      rem_sh;
    logic [XLEN-1:0]    rem_sub, rem_nx, quo_nx;
    logic               fits;
    logic               accept;

    assign shamt = in_b[SHAMT_W-1:0];

    // Operands are sign- or zero-extended to 2*XLEN, so one unsigned
    // multiplier yields the correct wrapped product for every flavour.
    always_comb begin
        mul_a = {{XLEN{in_a[XLEN-1] & ((in_op == OP_MULH) || (in_op == OP_MULHSU))}}, in_a};
        mul_b = {{XLEN{in_b[XLEN-1] & (in_op == OP_MULH)}}, in_b};
        mul_p = mul_a * mul_b;
    end

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        is_div  = 1'b0;
        case (in_op)
            OP_ADD:    alu_res = in_a + in_b;
            OP_SUB:    alu_res = in_a - in_b;
            OP_SLL:    alu_res = in_a << shamt;
            OP_SLT:    alu_res = {ZPAD[XLEN-1:1], $signed(in_a) < $signed(in_b)};
            OP_SLTU:   alu_res = {ZPAD[XLEN-1:1], in_a < in_b};
            OP_XOR:    alu_res = in_a ^ in_b;
            OP_SRL:    alu_res = in_a >> shamt;
            OP_SRA:    alu_res = $signed(in_a) >>> shamt;
            OP_OR:     alu_res = in_a | in_b;
            OP_AND:    alu_res = in_a & in_b;
            OP_EQ:     alu_res = {ZPAD[XLEN-1:1], in_a == in_b};
            OP_NE:     alu_res = {ZPAD[XLEN-1:1], in_a != in_b};
            OP_GE:     alu_res = {ZPAD[XLEN-1:1], $signed(in_a) >= $signed(in_b)};
            OP_GEU:    alu_res = {ZPAD[XLEN-1:1], in_a >= in_b};
            OP_MUL:    alu_res = mul_p[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  alu_res = mul_p[2*XLEN-1:XLEN];
            OP_DIV,
            OP_DIVU,
            OP_REM,
            OP_REMU:   is_div = 1'b1;
            default:   alu_ill = 1'b1;
        endcase
    end

    // Divide-by-zero and signed overflow have fixed answers and skip the loop.
    always_comb begin
        div_sgn = (in_op == OP_DIV) || (in_op == OP_REM);
        div_rem = (in_op == OP_REM) || (in_op == OP_REMU);
        b_zero  = (in_b == '0);
        ovf     = div_sgn && (in_a == MIN_NEG) && (in_b == '1);
        fast    = b_zero || ovf;
        abs_a   = (div_sgn && in_a[XLEN-1]) ? -in_a : in_a;
        abs_b   = (div_sgn && in_b[XLEN-1]) ? -in_b : in_b;
        if (b_zero) fast_res = div_rem ? in_a : '1;
        else        fast_res = div_rem ? '0 : in_a;
    end

    // One restoring step: the dividend shifts out of quo_q into rem_q,
    // and the quotient bit shifts into the vacated LSB of quo_q.
    always_comb begin
        rem_sh  = {rem_q, quo_q[XLEN-1]};
        fits    = rem_sh >= {1'b0, dvs_q};
        rem_sub = rem_sh[XLEN-1:0] - dvs_q;
        rem_nx  = fits ? rem_sub : rem_sh[XLEN-1:0];
        quo_nx  = {quo_q[XLEN-2:0], fits};
    end

    assign in_ready = !kill && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q && !out_ready;
        out_result_d  = out_result_q;
        out_illegal_d = out_illegal_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        cnt_d         = cnt_q;
        qneg_d        = qneg_q;
        rneg_d        = rneg_q;
        want_rem_d    = want_rem_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_div && !fast) begin
                        state_d    = S_DIV;
                        rem_d      = '0;
                        quo_d      = abs_a;
                        dvs_d      = abs_b;
                        cnt_d      = SHAMT_W'(XLEN - 1);
                        qneg_d     = div_sgn && (in_a[XLEN-1] ^ in_b[XLEN-1]);
                        rneg_d     = div_sgn && in_a[XLEN-1];
                        want_rem_d = div_rem;
                    end else begin
                        out_valid_d   = 1'b1;
                        out_result_d  = is_div ? fast_res : alu_res;
                        out_illegal_d = alu_ill;
                    end
                end
            end
            S_DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d       = S_IDLE;
                    out_valid_d   = 1'b1;
                    out_illegal_d = 1'b0;
                    if (want_rem_q) out_result_d = rneg_q ? -rem_nx : rem_nx;
                    else            out_result_d = qneg_q ? -quo_nx : quo_nx;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (kill) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_illegal_q <= 1'b0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            cnt_q         <= '0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            want_rem_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_illegal_q <= out_illegal_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            cnt_q         <= cnt_d;
            qneg_q        <= qneg_d;
            rneg_q        <= rneg_d;
            want_rem_q    <= want_rem_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_mdu_alu.sv
// tb_mdu_alu: directed and randomized checks of mdu_alu against an
// arithmetic reference model; set XLEN to 32 or 64.
module tb_mdu_alu;
    parameter int XLEN = 32;

    localparam logic [63:0] M    = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                : ((64'd1 << XLEN) - 64'd1);
    localparam logic [63:0] MINS = 64'd1 << (XLEN - 1);
    localparam logic [63:0] MAXS = M >> 1;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_illegal;

    int checks = 0;
    int errors = 0;

    mdu_alu #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .kill       (kill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [127:0] sx(input logic [63:0] x);
        logic [127:0] t;
        t = {64'd0, x & M};
        if (x[XLEN-1]) t = t | ~{64'd0, M};
        return $signed(t);
    endfunction

    // Reference: returns {illegal, result} using wide plain arithmetic.
    function automatic logic [64:0] model(input logic [4:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [127:0] p;
        logic [127:0]        pu;
        logic [63:0]         r;
        logic                ill;
        int                  sh;
        sh  = int'(b % 64'(XLEN));
        r   = '0;
        ill = 1'b0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << sh;
            5'd3:  r = {63'd0, sx(a) < sx(b)};
            5'd4:  r = {63'd0, a < b};
            5'd5:  r = a ^ b;
            5'd6:  r = a >> sh;
            5'd7:  r = 64'(sx(a) >>> sh);
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: r = {63'd0, a == b};
            5'd11: r = {63'd0, a != b};
            5'd12: r = {63'd0, sx(a) >= sx(b)};
            5'd13: r = {63'd0, a >= b};
            5'd16: begin p = sx(a) * sx(b); r = p[63:0]; end
            5'd17: begin p = sx(a) * sx(b); r = 64'(p >> XLEN); end
            5'd18: begin p = sx(a) * $signed({64'd0, b}); r = 64'(p >> XLEN); end
            5'd19: begin pu = {64'd0, a} * {64'd0, b}; r = 64'(pu >> XLEN); end
            5'd20: r = (b == 0) ? M : ((a == MINS && b == M) ? a : 64'(sx(a) / sx(b)));
            5'd21: r = (b == 0) ? M : a / b;
            5'd22: r = (b == 0) ? a : ((a == MINS && b == M) ? 64'd0 : 64'(sx(a) % sx(b)));
            5'd23: r = (b == 0) ? a : a % b;
            default: ill = 1'b1;
        endcase
        return {ill, r & M};
    endfunction

    function automatic int exp_lat(input logic [4:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
        if (op < 5'd20 || op > 5'd23 || b == 0) return 1;
        if ((op == 5'd20 || op == 5'd22) && a == MINS && b == M) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return M;
            3: return MINS;
            4: return MAXS;
            default: return {$urandom, $urandom} & M;
        endcase
    endfunction

    task automatic do_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic ei, input string tag);
        int lat;
        int want;
        want      = exp_lat(op, a, b);
        in_op     = op;
        in_a      = a[XLEN-1:0];
        in_b      = b[XLEN-1:0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "/rdy"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < XLEN + 8) begin
            chk({tag, "/busy"}, 64'(in_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        chk({tag, "/lat"}, 64'(lat), 64'(want));
        chk({tag, "/res"}, 64'(out_result), er);
        chk({tag, "/ill"}, 64'(out_illegal), 64'(ei));
    endtask

    task automatic rnd_op(input logic [4:0] op, input string tag);
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] m;
        a = rnd_val();
        b = rnd_val();
        m = model(op, a, b);
        do_op(op, a, b, m[63:0], m[64], tag);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] m;
        logic [4:0]  op;
        int          seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        kill      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst/valid", 64'(out_valid), 64'd0);
        chk("rst/res", 64'(out_result), 64'd0);
        chk("rst/ill", 64'(out_illegal), 64'd0);
        chk("rst/rdy", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        do_op(5'd0, MAXS, 64'd1, MINS, 1'b0, "add_ovf");
        do_op(5'd7, MINS, 64'(XLEN + 3), M ^ (M >> 4), 1'b0, "sra");
        do_op(5'd4, 64'd1, M, 64'd1, 1'b0, "sltu");
        do_op(5'd17, M, M, 64'd0, 1'b0, "mulh");
        do_op(5'd19, M, M, M - 64'd1, 1'b0, "mulhu");
        do_op(5'd18, M, 64'd2, M, 1'b0, "mulhsu");
        do_op(5'd16, 64'd3, M - 64'd4, M - 64'd14, 1'b0, "mul");
        do_op(5'd20, M - 64'd6, 64'd2, M - 64'd2, 1'b0, "div");
        do_op(5'd22, M - 64'd6, 64'd2, M, 1'b0, "rem");
        do_op(5'd21, 64'd5, 64'd0, M, 1'b0, "divu_z");
        do_op(5'd22, 64'd5, 64'd0, 64'd5, 1'b0, "rem_z");
        do_op(5'd20, MINS, M, MINS, 1'b0, "div_ovf");
        do_op(5'd22, MINS, M, 64'd0, 1'b0, "rem_ovf");
        do_op(5'd14, 64'd9, 64'd9, 64'd0, 1'b1, "illegal14");
        do_op(5'd31, 64'd9, 64'd9, 64'd0, 1'b1, "illegal31");
        do_op(5'd21, 64'd100, 64'd7, 64'd14, 1'b0, "divu");
        do_op(5'd23, 64'd100, 64'd7, 64'd2, 1'b0, "remu");
        @(negedge clk);

        in_op     = 5'd0;
        in_a      = XLEN'(5);
        in_b      = XLEN'(7);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("bp/rdy0", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_op = 5'd1;
        for (int i = 0; i < 4; i++) begin
            chk("bp/valid", 64'(out_valid), 64'd1);
            chk("bp/res", 64'(out_result), 64'd12);
            chk("bp/rdy", 64'(in_ready), 64'd0);
            @(negedge clk);
        end

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 5'($urandom_range(0, 19));
            a  = rnd_val();
            b  = rnd_val();
            m  = model(op, a, b);
            in_valid = 1'b1;
            in_op    = op;
            in_a     = a[XLEN-1:0];
            in_b     = b[XLEN-1:0];
            #1;
            chk("stream/rdy", 64'(in_ready), 64'd1);
            @(negedge clk);
            chk("stream/valid", 64'(out_valid), 64'd1);
            chk("stream/res", 64'(out_result), m[63:0]);
            chk("stream/ill", 64'(out_illegal), 64'(m[64]));
        end
        in_valid = 1'b0;
        @(negedge clk);

        in_op    = 5'd21;
        in_a     = XLEN'(1000);
        in_b     = XLEN'(3);
        in_valid = 1'b1;
        #1;
        chk("kill/rdy0", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        kill     = 1'b1;
        in_valid = 1'b1;
        in_op    = 5'd0;
        #1;
        chk("kill/rdy_forced", 64'(in_ready), 64'd0);
        @(negedge clk);
        kill     = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("kill/valid", 64'(out_valid), 64'd0);
        chk("kill/rdy", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (XLEN + 4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("kill/no_result", 64'(seen), 64'd0);

        do_op(5'd0, 64'd5, 64'd7, 64'd12, 1'b0, "pre_rst");
        in_op    = 5'd21;
        in_a     = XLEN'(1000);
        in_b     = XLEN'(3);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst/valid", 64'(out_valid), 64'd0);
        chk("mrst/res", 64'(out_result), 64'd0);
        chk("mrst/ill", 64'(out_illegal), 64'd0);
        chk("mrst/rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (XLEN + 4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mrst/no_result", 64'(seen), 64'd0);
        do_op(5'd21, 64'd1000, 64'd3, 64'd333, 1'b0, "post_rst");

        for (int i = 0; i < 150; i++) begin
            rnd_op(5'($urandom_range(0, 31)), "rnd");
        end
        for (int i = 0; i < 30; i++) begin
            rnd_op(5'($urandom_range(20, 23)), "rnd_div");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_alu.md
Name: mdu_alu

Overview:
- Parametrised, sequential successor to the combinational RV32I ALU.
- Executes base integer ALU/compare ops and the M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) behind a valid/ready handshake.
- Single-cycle ops and multiplies return in 1 cycle. Divide/remainder use an iterative radix-2 restoring divider.
- Sits between decode/operand-read and writeback; stalls the issue side while a divide is in flight.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- SHAMT_W, $clog2(XLEN), number of shift-amount bits used from operand b.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request this cycle
- in_op  in  5  operation code (encoding below)
- in_a  in  XLEN  operand a (rs1 or pc)
- in_b  in  XLEN  operand b (rs2 or sign-extended imm)
- kill  in  1  abort in-flight op; drop pending result
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  result
- out_illegal  out  1  in_op was an unassigned code

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 EQ, 11 NE, 12 GE, 13 GEU
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU
  - All other codes are illegal.
- Reset: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_illegal=0, divider registers 0.
- Accept condition: in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Back-to-back single-cycle ops therefore sustain 1 op/cycle.
- Single-cycle ops (0-19, illegal):
  - Result is registered; out_valid asserts the cycle after accept.
  - Shifts use in_b[SHAMT_W-1:0] only.
  - Compares return 0 or 1, zero-extended.
  - MUL returns the low XLEN bits of the product. MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product, with signedness per RISC-V M.
  - Illegal op: out_result=0, out_illegal=1, same latency.
- Divide ops (20-23):
  - Fast path with latency 1:
    - b==0: quotient = all ones; remainder = a.
    - Signed overflow (a = most-negative, b = -1): quotient = a; remainder = 0.
  - Otherwise: IDLE -> DIV, taking absolute values for signed ops.
  - DIV runs exactly XLEN iterations, 1 quotient bit per cycle.
  - DIV -> IDLE after the last iteration, with sign fix-up applied:
    - Quotient is negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
  - The result is registered the same cycle; out_valid asserts XLEN+1 cycles after accept.
  - in_ready=0 for the whole time in DIV.
- Output hold: out_result and out_illegal stay stable while out_valid && !out_ready. out_valid drops on the cycle after the handshake unless a new result is loaded in that same cycle.
- kill:
  - Forces state=IDLE and out_valid=0 next cycle; discards any in-flight divide.
  - A request presented in the same cycle as kill is not accepted (in_ready is forced to 0 while kill=1).
- Reset mid-divide: returns immediately to the reset values.
- Results are always XLEN wide. No X is ever driven on out_result.

Test Plan:
- Single-cycle ALU ops, XLEN=32:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, latency 1.
  - SRA 0x80000000 by b=0x23 (only shamt 3 used) -> 0xF0000000.
  - SLTU 1 vs 0xFFFFFFFF -> 1.
- Multiply:
  - MULH 0xFFFFFFFF*0xFFFFFFFF -> 0.
  - MULHU same operands -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
  - MUL 3*-5 -> 0xFFFFFFF1.
- Divide:
  - DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, each with out_valid exactly 33 cycles after accept.
  - in_ready stays 0 throughout the divide.
- Divide corner cases, each completing in 1 cycle:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000.
  - REM same operands -> 0.
- Backpressure and streaming:
  - Hold out_ready=0 for 4 cycles after an ADD: result stays stable and in_ready=0.
  - Then issue 8 back-to-back ops with out_ready=1: throughput is 1 op/cycle and results arrive in order.
- kill and reset:
  - Assert kill 10 cycles into a DIVU: no out_valid appears, and in_ready=1 the next cycle.
  - Repeat with rst instead of kill: all outputs return to their reset values.
  - Rerun the full suite with XLEN=64; the divide latency becomes 65 cycles.
